// File: rtl/corelet_out_stage.sv
// -----------------------------------------------------------------------------
// corelet_out_stage
//
// Output stage between the MAC array south outputs and the psum SRAM path.
//   * WS mode (mode_q = 0): each column pushes into its own lane FIFO whenever
//     col_valid[i] is high, so column-skewed psums line up into whole rows.
//   * OS mode (mode_q = 1): a drain pulse starts an IDLE/DRAIN FSM that asks
//     the array to shift 'row' result rows south and captures every column
//     on each shift. The FSM stalls while any lane is full.
//   * Read side: rows leave under rd_valid/rd_ready. A per-column SFP
//     accumulates popped rows, with an optional ReLU on the output view.
//
// Optional feature macro: OUT_STAGE_RELU_EN
//   defined   -> sfp_out[i] = 0 when acc[i] is negative, else acc[i]
//   undefined -> sfp_out[i] = acc[i] (raw signed accumulator)
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   mode             0 = WS, 1 = OS (captured into mode_q while IDLE)
//   col_valid        per-column psum valid (WS)
//   col_psum         array south outputs, column i at [psum_bw*i +: psum_bw]
//   drain            single-cycle pulse starting an OS drain
//   array_shift      asks the array to shift one OS row south
//   busy             drain FSM not IDLE
//   rd_ready         consumer accepts the head row
//   rd_valid         every lane holds at least one entry
//   rd_data          head row (show-ahead)
//   acc_en, acc_clr  accumulate popped row / clear accumulators
//   sfp_out          accumulator view (optionally ReLU'd)
//   overflow         sticky: a WS write hit a full lane
// -----------------------------------------------------------------------------
module corelet_out_stage #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mode,
    input  logic [col-1:0]           col_valid,
    input  logic [psum_bw*col-1:0]   col_psum,
    input  logic                     drain,
    output logic                     array_shift,
    output logic                     busy,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [psum_bw*col-1:0]   rd_data,
    input  logic                     acc_en,
    input  logic                     acc_clr,
    output logic [psum_bw*col-1:0]   sfp_out,
    output logic                     overflow
);

    localparam int AW = $clog2(depth);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(row + 1);
    // Pointer difference that marks a full lane: wrap bits differ, index equal.
    localparam logic [PW-1:0] PTR_WRAP = PW'(1) << AW;

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            mode_q_reg;
    logic            overflow_reg;
    logic [PW-1:0]   rd_ptr_reg;

    logic [col-1:0]  lane_full;
    logic [col-1:0]  lane_empty;
    logic [col-1:0]  lane_we;
    logic            any_full;
    logic            ws_active;
    logic            ws_drop;
    logic            pop;

    assign any_full  = |lane_full;
    assign ws_active = (state_reg == IDLE) && !mode_q_reg;
    // Full is judged before any same-cycle pop, so such writes are dropped.
    assign ws_drop   = ws_active && |(col_valid & lane_full);
    assign rd_valid  = &(~lane_empty);
    assign pop       = rd_valid && rd_ready;
    assign busy      = (state_reg == DRAIN);
    assign overflow  = overflow_reg;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        array_shift = 1'b0;
        case (state_reg)
            IDLE: begin
                if (drain && mode_q_reg) begin
                    state_next = DRAIN;
                    cnt_next   = '0;
                end
            end
            DRAIN: begin
                // Exit one cycle after the final shift; no shift that cycle.
                if (cnt_reg == CW'(row)) begin
                    state_next = IDLE;
                end else if (!any_full) begin
                    array_shift = 1'b1;
                    cnt_next    = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------- mode, overflow, rd ptr
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q_reg   <= 1'b0;
            overflow_reg <= 1'b0;
            rd_ptr_reg   <= '0;
        end else begin
            if (state_reg == IDLE) begin
                mode_q_reg <= mode;
            end
            if (ws_drop) begin
                overflow_reg <= 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------- lanes
    generate
        for (genvar gi = 0; gi < col; gi++) begin : g_lane
            logic [PW-1:0]      wr_ptr_reg;
            logic [psum_bw-1:0] mem [depth];
            logic [psum_bw-1:0] acc_reg;
            logic [psum_bw-1:0] head;

            assign lane_full[gi]  = ((wr_ptr_reg ^ rd_ptr_reg) == PTR_WRAP);
            assign lane_empty[gi] = (wr_ptr_reg == rd_ptr_reg);
            // A DRAIN shift only happens when no lane is full.
            assign lane_we[gi]    = array_shift ||
                                    (ws_active && col_valid[gi] && !lane_full[gi]);

            always_ff @(posedge clk) begin
                if (lane_we[gi]) begin
                    mem[wr_ptr_reg[AW-1:0]] <= col_psum[gi*psum_bw +: psum_bw];
                end
            end

            // Show-ahead head entry; every lane shares the read index.
            assign head = mem[rd_ptr_reg[AW-1:0]];
            assign rd_data[gi*psum_bw +: psum_bw] = head;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    wr_ptr_reg <= '0;
                    acc_reg    <= '0;
                end else begin
                    if (lane_we[gi]) begin
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    end
                    if (acc_clr) begin
                        acc_reg <= '0;
                    end else if (pop && acc_en) begin
                        acc_reg <= acc_reg + head;
                    end
                end
            end

`ifdef OUT_STAGE_RELU_EN
            assign sfp_out[gi*psum_bw +: psum_bw] =
                acc_reg[psum_bw-1] ? '0 : acc_reg;
`else
            assign sfp_out[gi*psum_bw +: psum_bw] = acc_reg;
`endif
        end
    endgenerate

endmodule
